// File: rtl/scan_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_select_sequencer
// Description : Drives the a/b/c select lines and en strobe of a 3-to-8
//               decoder. It steps through unmasked channels with a
//               programmable slot length and break-before-make blanking.
//               It supports single-pass or continuous scans in ascending or
//               descending order.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_select_sequencer #(
    parameter int DIV = 4,   // active cycles per slot, 1..256
    parameter int GAP = 2    // blanking cycles between slots, 2..16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       mode,
    input  logic [7:0] skip_mask,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       en,
    output logic       busy,
    output logic       done
);

    localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W  = $clog2(GAP);

    localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(DIV - 1);
    localparam logic [GAP_W-1:0]  c_GAP_LAST  = GAP_W'(GAP - 1);
    localparam logic [7:0]        c_ALL_MASKED = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Channel search helpers. The result is {found, index}.
    // ------------------------------------------------------------------------

    // First channel of a scan: the lowest unmasked index when ascending, the
    // highest when descending. Later loop iterations override earlier ones,
    // so the loop order sets the priority.
    function automatic logic [3:0] f_first(input logic d, input logic [7:0] m);
        logic [3:0] r;
        r = 4'b0000;
        if (!d) begin
            for (int i = 7; i >= 0; i--) begin
                if (!m[i]) r = {1'b1, 3'(i)};
            end
        end else begin
            for (int i = 0; i <= 7; i++) begin
                if (!m[i]) r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Next channel after 'cur'. The loop walks distance k from 8 down to 1,
    // so the nearest candidate wins. Continuous scans wrap modulo 8, and
    // distance 8 reselects the current channel when it is the only one left.
    // Single-pass scans accept only candidates that do not wrap.
    function automatic logic [3:0] f_next(input logic [2:0] cur,
                                          input logic       d,
                                          input logic [7:0] m,
                                          input logic       single);
        logic [3:0] r;
        int         p;
        logic [2:0] idx;
        logic       in_range;
        r = 4'b0000;
        for (int k = 8; k >= 1; k--) begin
            p        = d ? ({29'd0, cur} - k) : ({29'd0, cur} + k);
            idx      = p[2:0];
            in_range = !single || ((p >= 0) && (p <= 7));
            if (in_range && !m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t              r_state,  w_state_nxt;
    logic [2:0]          r_sel,    w_sel_nxt;
    logic [2:0]          r_next,   w_next_nxt;
    logic                r_en,     w_en_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_mode,   w_mode_nxt;
    logic [SLOT_W-1:0]   r_slot,   w_slot_nxt;
    logic [GAP_W-1:0]    r_gap,    w_gap_nxt;

    logic [3:0]          w_first;
    logic [3:0]          w_after;

    assign w_first = f_first(dir, skip_mask);
    assign w_after = f_next(r_sel, dir, skip_mask, r_mode);

    // State, select, strobe and counter registers; reset returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_next  <= 3'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mode  <= 1'b0;
            r_slot  <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_next  <= w_next_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_mode  <= w_mode_nxt;
            r_slot  <= w_slot_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Next-state and registered-output logic for IDLE / ACTIVE / BLANK.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_next_nxt  = r_next;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_mode_nxt  = r_mode;
        w_slot_nxt  = r_slot;
        w_gap_nxt   = r_gap;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (skip_mask != c_ALL_MASKED) begin
                        w_state_nxt = S_ACTIVE;
                        w_sel_nxt   = w_first[2:0];
                        w_en_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_mode_nxt  = mode;
                        w_slot_nxt  = '0;
                    end else begin
                        // Nothing to scan: finish at once without going busy.
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_ACTIVE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_slot == c_SLOT_LAST) begin
                    w_en_nxt = 1'b0;
                    if (!w_after[3]) begin
                        // The pass is complete, or every channel is masked.
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Hold the select lines for one cycle after en falls.
                        w_state_nxt = S_BLANK;
                        w_next_nxt  = w_after[2:0];
                        w_gap_nxt   = '0;
                    end
                end else begin
                    w_slot_nxt = r_slot + SLOT_W'(1);
                end
            end

            S_BLANK: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    // Load the new channel on the first blanking edge, so it
                    // settles GAP-1 cycles before en rises again.
                    if (r_gap == '0) begin
                        w_sel_nxt = r_next;
                    end
                    if (r_gap == c_GAP_LAST) begin
                        w_state_nxt = S_ACTIVE;
                        w_en_nxt    = 1'b1;
                        w_slot_nxt  = '0;
                    end else begin
                        w_gap_nxt = r_gap + GAP_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign a    = r_sel[2];
    assign b    = r_sel[1];
    assign c    = r_sel[0];
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_select_sequencer
// Description : Directed self-checking bench for scan_select_sequencer with
//               hand-computed slot, blanking, stop and reset expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_select_sequencer;

    localparam int DIV = 4;
    localparam int GAP = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       dir;
    logic       mode;
    logic [7:0] skip_mask;
    logic       a, b, c, en, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    scan_select_sequencer #(.DIV(DIV), .GAP(GAP)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .mode      (mode),
        .skip_mask (skip_mask),
        .a         (a),
        .b         (b),
        .c         (c),
        .en        (en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: {en, a, b, c, busy, done}.
    logic [5:0] obs;
    assign obs = {en, a, b, c, busy, done};

    function automatic logic [5:0] pk(input logic e, input logic [2:0] ch,
                                      input logic bz, input logic dn);
        return {e, ch, bz, dn};
    endfunction

    // Count a comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b ({en,abc,busy,done})",
                     tag, got[5:0], exp[5:0]);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one full slot (DIV active cycles on ch, then GAP blank cycles:
    // the first still shows ch, the rest show nxt). Ends on nxt's first cycle.
    task automatic expect_slot(input string nm, input logic [2:0] ch,
                               input logic [2:0] nxt);
        for (int k = 0; k < DIV; k++) begin
            chk($sformatf("%s ch%0d act%0d", nm, ch, k), {26'd0, obs},
                {26'd0, pk(1'b1, ch, 1'b1, 1'b0)});
            tick();
        end
        for (int g = 0; g < GAP; g++) begin
            chk($sformatf("%s ch%0d blank%0d", nm, ch, g), {26'd0, obs},
                {26'd0, pk(1'b0, (g == 0) ? ch : nxt, 1'b1, 1'b0)});
            tick();
        end
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [2:0] seq [10];

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        dir = 1'b0; mode = 1'b0; skip_mask = 8'h00;
        tick(); tick();
        chk("reset state", {26'd0, obs}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle after reset", {26'd0, obs}, 32'd0);

        // All channels masked: done pulse only, never busy.
        skip_mask = 8'hFF; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("allmask done", {26'd0, obs}, {26'd0, pk(1'b0, 3'd0, 1'b0, 1'b1)});
        tick();
        chk("allmask after", {26'd0, obs}, 32'd0);

        // Single pass ascending over all eight channels.
        skip_mask = 8'h00; mode = 1'b1; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int ch = 0; ch < 7; ch++) expect_slot("sp", 3'(ch), 3'(ch + 1));
        for (int k = 0; k < DIV; k++) begin
            chk($sformatf("sp ch7 act%0d", k), {26'd0, obs},
                {26'd0, pk(1'b1, 3'd7, 1'b1, 1'b0)});
            tick();
        end
        chk("sp done", {26'd0, obs}, {26'd0, pk(1'b0, 3'd7, 1'b0, 1'b1)});
        tick();
        chk("sp done one cycle", {26'd0, obs}, {26'd0, pk(1'b0, 3'd7, 1'b0, 1'b0)});

        // Continuous descending with odd channels masked: 6,4,2,0,6,...
        seq = '{3'd6, 3'd4, 3'd2, 3'd0, 3'd6, 3'd4, 3'd2, 3'd0, 3'd6, 3'd4};
        mode = 1'b0; dir = 1'b1; skip_mask = 8'b1010_1010; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) expect_slot("cd", seq[i], seq[i + 1]);
        chk("cd wrap slot", {26'd0, obs}, {26'd0, pk(1'b1, 3'd4, 1'b1, 1'b0)});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cd stop active", {26'd0, obs}, {26'd0, pk(1'b0, 3'd4, 1'b0, 1'b0)});
        tick();
        chk("cd no done", {26'd0, obs}, {26'd0, pk(1'b0, 3'd4, 1'b0, 1'b0)});

        // Stop in BLANK between channels 2 and 3 with start held throughout.
        mode = 1'b1; dir = 1'b0; skip_mask = 8'h00; start = 1'b1;
        tick();
        expect_slot("sb", 3'd0, 3'd1);
        expect_slot("sb", 3'd1, 3'd2);
        for (int k = 0; k < DIV; k++) begin
            chk($sformatf("sb ch2 act%0d", k), {26'd0, obs},
                {26'd0, pk(1'b1, 3'd2, 1'b1, 1'b0)});
            tick();
        end
        chk("sb blank0", {26'd0, obs}, {26'd0, pk(1'b0, 3'd2, 1'b1, 1'b0)});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("sb stopped", {26'd0, obs}, {26'd0, pk(1'b0, 3'd2, 1'b0, 1'b0)});
        tick();
        chk("sb restart", {26'd0, obs}, {26'd0, pk(1'b1, 3'd0, 1'b1, 1'b0)});
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("sb stop again", {26'd0, obs}, 32'd0);

        // Continuous with only channel 3 unmasked.
        mode = 1'b0; dir = 1'b0; skip_mask = 8'hF7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) expect_slot("one", 3'd3, 3'd3);
        chk("one still active", {26'd0, obs}, {26'd0, pk(1'b1, 3'd3, 1'b1, 1'b0)});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("one stopped", {26'd0, obs}, {26'd0, pk(1'b0, 3'd3, 1'b0, 1'b0)});

        // Asynchronous reset in the middle of channel 5's active slot.
        mode = 1'b0; dir = 1'b0; skip_mask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int ch = 0; ch < 5; ch++) expect_slot("rs", 3'(ch), 3'(ch + 1));
        tick(); tick();
        chk("rs mid ch5", {26'd0, obs}, {26'd0, pk(1'b1, 3'd5, 1'b1, 1'b0)});
        #2;
        reset = 1'b1;
        #1;
        chk("rs async clear", {26'd0, obs}, 32'd0);
        tick();
        chk("rs held", {26'd0, obs}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rs idle", {26'd0, obs}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
